coco3_sdram_arbiter: RTL and testbench



---
 rtl/coco3_mem_pkg.sv | 22 ++
 rtl/ld_wr_fifo.sv | 47 ++++
 rtl/coco3_sdram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_coco3_sdram_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coco3_mem_pkg.sv
// rtl/coco3_mem_pkg.sv - shared types, defaults and priority helper for the CoCo3 SDRAM arbiter
package coco3_mem_pkg;

    localparam int DEF_ADDR_W   = 25;
    localparam int DEF_TIMEOUT  = 63;
    localparam int DEF_VID_MAX  = 4;
    localparam int DEF_LD_DEPTH = 4;

    typedef enum logic [1:0] {SRC_NONE, SRC_VID, SRC_LD, SRC_CPU} req_src_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

    // Fixed priority: starved CPU first, then video, loader backlog, plain CPU
    function automatic req_src_t pick_src(input logic force_cpu, input logic vid,
                                          input logic ld, input logic cpu);
        if (force_cpu) return SRC_CPU;
        if (vid)       return SRC_VID;
        if (ld)        return SRC_LD;
        if (cpu)       return SRC_CPU;
        return SRC_NONE;
    endfunction

endpackage

// File: rtl/ld_wr_fifo.sv
// rtl/ld_wr_fifo.sv - loader write buffer, power-of-2 depth, simultaneous push/pop
module ld_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable
    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[PW-1:0]];

    // Pointer advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/coco3_sdram_arbiter.sv
// rtl/coco3_sdram_arbiter.sv - single-outstanding arbiter: video, CPU and loader onto one SDRAM port
module coco3_sdram_arbiter
    import coco3_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int VID_MAX  = DEF_VID_MAX,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int LD_DEPTH = DEF_LD_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_ready,
    output logic [15:0]       vid_data,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic              cpu_ready,
    output logic [7:0]        cpu_dout,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_full,
    output logic              ld_overflow,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_din,
    input  logic              mem_ack,
    input  logic              mem_ready,
    input  logic [15:0]       mem_dout,
    input  logic              mem_busy,
    output logic              timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int STK_W = $clog2(VID_MAX + 1);
    localparam int LD_W  = ADDR_W + 8;

    arb_state_t       state;
    req_src_t         src;
    req_src_t         pick;
    logic [CNT_W-1:0] wait_cnt;
    logic [STK_W-1:0] vid_streak;
    logic [LD_W-1:0]  ld_head;
    logic             ld_empty;
    logic             ld_pop;
    logic             grant;
    logic             ret_done;
    logic             ret_abort;
    logic [15:0]      ret_data;

    assign pick   = pick_src(cpu_req && (vid_streak == STK_W'(VID_MAX)),
                             vid_req, !ld_empty, cpu_req);
    assign grant  = (state == IDLE) && !mem_busy && (pick != SRC_NONE);
    assign ld_pop = grant && (pick == SRC_LD);

    ld_wr_fifo #(
        .DEPTH (LD_DEPTH),
        .WIDTH (LD_W)
    ) u_ld_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ld_wr),
        .pop   (ld_pop),
        .din   ({ld_addr, ld_data}),
        .dout  (ld_head),
        .full  (ld_full),
        .empty (ld_empty)
    );

    // Completion detect: normal ready (also when it coincides with ack) or timeout abort
    always_comb begin
        ret_done  = 1'b0;
        ret_abort = 1'b0;
        ret_data  = mem_dout;
        if (state == ISSUE) begin
            ret_done = mem_ack && mem_ready;
        end else if (state == WAIT) begin
            if (mem_ready) begin
                ret_done = 1'b1;
            end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                ret_done  = 1'b1;
                ret_abort = 1'b1;
                ret_data  = 16'hFFFF;
            end
        end
    end

    // Arbitration FSM with registered downstream request and requester pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            src         <= SRC_NONE;
            wait_cnt    <= '0;
            vid_streak  <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_din     <= '0;
            vid_ack     <= 1'b0;
            vid_ready   <= 1'b0;
            vid_data    <= '0;
            cpu_ack     <= 1'b0;
            cpu_ready   <= 1'b0;
            cpu_dout    <= '0;
            ld_overflow <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            vid_ack   <= 1'b0;
            vid_ready <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_ready <= 1'b0;
            if (ld_wr && ld_full && !ld_pop) ld_overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (grant) begin
                        src     <= pick;
                        mem_req <= 1'b1;
                        state   <= ISSUE;
                        case (pick)
                            SRC_VID: begin
                                mem_addr <= vid_addr;
                                mem_we   <= 1'b0;
                                mem_din  <= '0;
                            end
                            SRC_LD: begin
                                mem_addr <= ld_head[LD_W-1:8];
                                mem_we   <= 1'b1;
                                mem_din  <= ld_head[7:0];
                            end
                            default: begin
                                mem_addr <= cpu_addr;
                                mem_we   <= !cpu_rnw;
                                mem_din  <= cpu_din;
                            end
                        endcase
                        // Only video grants made while the CPU waits build the streak
                        if (pick == SRC_CPU || !cpu_req)
                            vid_streak <= '0;
                        else if (pick == SRC_VID && vid_streak != STK_W'(VID_MAX))
                            vid_streak <= vid_streak + STK_W'(1);
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= WAIT;
                        if (src == SRC_VID) vid_ack <= 1'b1;
                        if (src == SRC_CPU) cpu_ack <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!mem_ready) wait_cnt <= wait_cnt + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase

            if (ret_done) begin
                state <= IDLE;
                if (ret_abort) timeout_err <= 1'b1;
                if (src == SRC_VID) begin
                    vid_ready <= 1'b1;
                    vid_data  <= ret_data;
                end
                if (src == SRC_CPU) begin
                    cpu_ready <= 1'b1;
                    cpu_dout  <= mem_addr[0] ? ret_data[15:8] : ret_data[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_coco3_sdram_arbiter.sv
// tb/tb_coco3_sdram_arbiter.sv - self-checking bench for coco3_sdram_arbiter
module tb_coco3_sdram_arbiter;
    localparam int AW   = 25;
    localparam int TMO  = 63;
    localparam int VMAX = 4;
    localparam int LDD  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack, vid_ready;
    logic [15:0]   vid_data;
    logic          cpu_req = 1'b0, cpu_rnw = 1'b1;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_din = '0;
    logic          cpu_ack, cpu_ready;
    logic [7:0]    cpu_dout;
    logic          ld_wr = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_data = '0;
    logic          ld_full, ld_overflow;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_ack = 1'b0, mem_ready = 1'b0, mem_busy = 1'b0;
    logic [15:0]   mem_dout = '0;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;
    int ack_dly = 1;
    int rdy_dly = 2;

    logic [7:0] mdl [256];
    logic [7:0] shadow [256];

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [7:0]    din;
    } wr_t;
    wr_t log_q[$];

    coco3_sdram_arbiter dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_ready(vid_ready), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_ready(cpu_ready), .cpu_dout(cpu_dout),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_full(ld_full), .ld_overflow(ld_overflow),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
        .mem_ack(mem_ack), .mem_ready(mem_ready), .mem_dout(mem_dout), .mem_busy(mem_busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Downstream controller model: ack ack_dly cycles and ready rdy_dly cycles after mem_req rises
    initial begin : responder
        int k;
        bit busy;
        logic [15:0] rd;
        wr_t e;
        k = 0; busy = 0; rd = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_ready = 1'b0;
            if (reset) begin
                busy = 0; k = 0;
            end else begin
                if (mem_req && (!busy || k >= ack_dly)) begin busy = 1; k = 0; end
                if (busy) begin
                    k++;
                    if (k == ack_dly) begin
                        mem_ack = 1'b1;
                        e.addr = mem_addr; e.we = mem_we; e.din = mem_din;
                        log_q.push_back(e);
                        if (mem_we) mdl[mem_addr[7:0]] = mem_din;
                        rd = {mdl[{mem_addr[7:1], 1'b1}], mdl[{mem_addr[7:1], 1'b0}]};
                    end
                    if (rdy_dly != 0 && k == rdy_dly) begin
                        mem_ready = 1'b1;
                        mem_dout = rd;
                        busy = 0;
                    end
                end
            end
        end
    end

    // Drive one video or CPU request and record pulse counts and their cycle indices
    task automatic txn(input bit vid, input bit rnw, input logic [7:0] addr, input logic [7:0] din,
                       input int limit, output logic [15:0] data, output int n_ack, output int n_rdy,
                       output int c_req, output int c_ack, output int c_rdy);
        int after;
        n_ack = 0; n_rdy = 0; c_req = -1; c_ack = -1; c_rdy = -1; data = '0; after = 0;
        @(negedge clk);
        if (vid) begin
            vid_req = 1'b1; vid_addr = {17'd0, addr};
        end else begin
            cpu_req = 1'b1; cpu_rnw = rnw; cpu_addr = {17'd0, addr}; cpu_din = din;
        end
        for (int i = 1; i <= limit && after < 3; i++) begin
            @(negedge clk);
            if (mem_req && c_req < 0) c_req = i;
            if (vid ? vid_ack : cpu_ack) begin
                n_ack++;
                if (c_ack < 0) c_ack = i;
                if (vid) vid_req = 1'b0; else cpu_req = 1'b0;
            end
            if (vid ? vid_ready : cpu_ready) begin
                n_rdy++;
                if (c_rdy < 0) c_rdy = i;
                data = vid ? vid_data : {8'h00, cpu_dout};
            end
            if (c_rdy >= 0) after++;
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({vid_ack, vid_ready, cpu_ack, cpu_ready, mem_req, mem_we, ld_full, ld_overflow, timeout_err} !== 9'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000000",
                     {vid_ack, vid_ready, cpu_ack, cpu_ready, mem_req, mem_we, ld_full, ld_overflow, timeout_err});
        end
        checks++;
        if ({vid_data, cpu_dout, mem_addr, mem_din} !== 57'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {vid_data, cpu_dout, mem_addr, mem_din});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b expected 0", mem_req); end
    endtask

    task automatic test_cpu_read();
        logic [15:0] d;
        int na, nr, cq, ca, cr;
        shadow[0] = 8'h5A; mdl[0] = 8'h5A;
        shadow[1] = 8'hA5; mdl[1] = 8'hA5;
        ack_dly = 2; rdy_dly = 5;
        txn(0, 1, 8'h01, 8'h00, 40, d, na, nr, cq, ca, cr);
        checks++;
        if (cq !== 1) begin errors++; $display("FAIL cpu_read_req_latency: got %0d expected 1", cq); end
        checks++;
        if (na !== 1 || ca !== 3) begin errors++; $display("FAIL cpu_read_ack: got n=%0d at %0d expected n=1 at 3", na, ca); end
        checks++;
        if (nr !== 1 || cr !== 6) begin errors++; $display("FAIL cpu_read_ready: got n=%0d at %0d expected n=1 at 6", nr, cr); end
        checks++;
        if (d[7:0] !== 8'hA5) begin errors++; $display("FAIL cpu_read_data: got %h expected a5", d[7:0]); end
    endtask

    task automatic test_ack_ready_same();
        logic [15:0] d;
        logic [7:0]  a;
        int na, nr, cq, ca, cr;
        a = 8'($urandom_range(0, 255));
        ack_dly = 3; rdy_dly = 3;
        txn(0, 1, a, 8'h00, 40, d, na, nr, cq, ca, cr);
        checks++;
        if (na !== 1 || nr !== 1 || ca !== 4 || cr !== 4) begin
            errors++;
            $display("FAIL same_cycle_pulses: got ack %0d@%0d ready %0d@%0d expected 1@4 1@4", na, ca, nr, cr);
        end
        checks++;
        if (d[7:0] !== shadow[a]) begin errors++; $display("FAIL same_cycle_data: got %h expected %h", d[7:0], shadow[a]); end
        ack_dly = 1; rdy_dly = 2;
        txn(1, 1, a, 8'h00, 40, d, na, nr, cq, ca, cr);
        checks++;
        if (cq !== 1 || nr !== 1) begin errors++; $display("FAIL same_cycle_back_to_idle: got req@%0d ready n=%0d expected req@1 n=1", cq, nr); end
    endtask

    task automatic test_starvation();
        for (int round = 0; round < 3; round++) begin
            bit seq[$];
            bit raised, prev;
            int pre, ngr;
            ack_dly = $urandom_range(1, 3);
            rdy_dly = ack_dly + $urandom_range(1, 3);
            pre = $urandom_range(1, 3);
            ngr = 0; raised = 0; prev = 0;
            @(negedge clk);
            vid_addr = 25'h40; cpu_addr = 25'h81; cpu_rnw = 1'b1; vid_req = 1'b1;
            for (int i = 0; i < 400 && seq.size() < VMAX + 2; i++) begin
                @(negedge clk);
                if (mem_req && !prev) begin
                    if (raised) seq.push_back(mem_addr == 25'h81);
                    else ngr++;
                end
                prev = mem_req;
                if (cpu_ack) cpu_req = 1'b0;
                if (!raised && ngr >= pre) begin cpu_req = 1'b1; raised = 1; end
            end
            checks++;
            if (seq.size() !== VMAX + 2) begin
                errors++;
                $display("FAIL starve_grant_count: got %0d expected %0d", seq.size(), VMAX + 2);
            end else begin
                for (int j = 0; j < VMAX + 2; j++) begin
                    checks++;
                    if (seq[j] !== (j == VMAX)) begin
                        errors++;
                        $display("FAIL starve_grant_%0d: got cpu=%0d expected cpu=%0d", j, seq[j], (j == VMAX));
                    end
                end
            end
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (cpu_ack) cpu_req = 1'b0;
                if (vid_ack) begin vid_req = 1'b0; break; end
            end
            cpu_req = 1'b0;
            vid_req = 1'b0;
            repeat (12) @(negedge clk);
            checks++;
            if (dut.vid_streak !== 3'd0) begin errors++; $display("FAIL starve_streak_clear: got %0d expected 0", dut.vid_streak); end
        end
    endtask

    task automatic test_loader();
        wr_t exp[$];
        wr_t e;
        ack_dly = 1; rdy_dly = 3;
        mem_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            ld_wr = 1'b1;
            ld_addr = 25'($urandom_range(0, 255));
            ld_data = 8'($urandom);
            if (exp.size() < LDD) begin
                e.addr = ld_addr; e.we = 1'b1; e.din = ld_data;
                exp.push_back(e);
                shadow[ld_addr[7:0]] = ld_data;
            end
            @(negedge clk);
            if (i == LDD - 1) begin
                checks++;
                if (ld_full !== 1'b1 || ld_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ld_exactly_full: got full=%b ovf=%b expected full=1 ovf=0", ld_full, ld_overflow);
                end
            end
        end
        ld_wr = 1'b0;
        checks++;
        if (ld_full !== 1'b1 || ld_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ld_overflow: got full=%b ovf=%b expected full=1 ovf=1", ld_full, ld_overflow);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL busy_blocks_grant: got mem_req=%b expected 0", mem_req); end
        log_q.delete();
        mem_busy = 1'b0;
        for (int i = 0; i < 80 && log_q.size() < LDD; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        checks++;
        if (log_q.size() !== LDD) begin
            errors++;
            $display("FAIL ld_drain_count: got %0d expected %0d", log_q.size(), LDD);
        end else begin
            for (int j = 0; j < LDD; j++) begin
                checks++;
                if (log_q[j].addr !== exp[j].addr || log_q[j].we !== 1'b1 || log_q[j].din !== exp[j].din) begin
                    errors++;
                    $display("FAIL ld_write_%0d: got a=%h we=%b d=%h expected a=%h we=1 d=%h", j,
                             log_q[j].addr, log_q[j].we, log_q[j].din, exp[j].addr, exp[j].din);
                end
            end
        end
        checks++;
        if (ld_full !== 1'b0 || ld_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ld_after_drain: got full=%b ovf=%b expected full=0 ovf=1", ld_full, ld_overflow);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] d;
        int na, nr, cq, ca, cr;
        ack_dly = 2; rdy_dly = 0;
        txn(1, 1, 8'h10, 8'h00, 120, d, na, nr, cq, ca, cr);
        checks++;
        if (na !== 1 || ca !== 3) begin errors++; $display("FAIL timeout_ack: got n=%0d at %0d expected n=1 at 3", na, ca); end
        checks++;
        if (nr !== 1 || cr !== 3 + TMO) begin errors++; $display("FAIL timeout_ready: got n=%0d at %0d expected n=1 at %0d", nr, cr, 3 + TMO); end
        checks++;
        if (d !== 16'hFFFF) begin errors++; $display("FAIL timeout_data: got %h expected ffff", d); end
        repeat (5) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err); end
        rdy_dly = 2;
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic [7:0]  a;
        int na, nr, cq, ca, cr;
        ack_dly = 10; rdy_dly = 12;
        @(negedge clk);
        cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 25'h33; cpu_din = 8'hC3;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_mid_issue: got mem_req=%b expected 1", mem_req); end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mid_async: got mem_req=%b expected 0", mem_req); end
        checks++;
        if ({vid_ack, vid_ready, cpu_ack, cpu_ready, mem_we, ld_full, ld_overflow, timeout_err, vid_data, cpu_dout, mem_addr, mem_din} !== 65'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected 0",
                     {vid_ack, vid_ready, cpu_ack, cpu_ready, mem_we, ld_full, ld_overflow, timeout_err, vid_data, cpu_dout, mem_addr, mem_din});
        end
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ack_dly = 2; rdy_dly = 4;
        a = 8'($urandom_range(0, 255));
        txn(0, 1, a, 8'h00, 40, d, na, nr, cq, ca, cr);
        checks++;
        if (na !== 1 || nr !== 1 || ca !== 3 || cr !== 5 || d[7:0] !== shadow[a]) begin
            errors++;
            $display("FAIL after_reset_read: got ack %0d@%0d ready %0d@%0d data %h expected 1@3 1@5 data %h",
                     na, ca, nr, cr, d[7:0], shadow[a]);
        end
    endtask

    task automatic test_random();
        logic [15:0] d, expv;
        logic [7:0]  a, wd;
        int op, na, nr, cq, ca, cr;
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 2);
            a = 8'($urandom_range(0, 255));
            wd = 8'($urandom);
            ack_dly = $urandom_range(1, 4);
            rdy_dly = ack_dly + $urandom_range(0, 4);
            expv = (op == 2) ? {shadow[{a[7:1], 1'b1}], shadow[{a[7:1], 1'b0}]} : {8'h00, shadow[a]};
            txn(op == 2, op != 0, a, wd, 60, d, na, nr, cq, ca, cr);
            if (op == 0) shadow[a] = wd;
            checks++;
            if (na !== 1 || nr !== 1 || ca !== ack_dly + 1 || cr !== rdy_dly + 1) begin
                errors++;
                $display("FAIL rand_timing_%0d: got ack %0d@%0d ready %0d@%0d expected 1@%0d 1@%0d",
                         it, na, ca, nr, cr, ack_dly + 1, rdy_dly + 1);
            end
            if (op != 0) begin
                checks++;
                if (d !== expv) begin errors++; $display("FAIL rand_data_%0d: got %h expected %h", it, d, expv); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            shadow[i] = 8'($urandom);
            mdl[i] = shadow[i];
        end
        test_reset();
        test_cpu_read();
        test_ack_ready_same();
        test_starvation();
        test_loader();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
